// File: rtl/eforth_dstack.sv
// eforth_dstack: data stack for the eForth core.
// TOS and second-of-stack live in registers so the upstream ALU sees stable
// operands all cycle; deeper items spill into a small register-file RAM.
// Also provides a combinational PICK read port, depth, and sticky error flags.
module eforth_dstack #(
  parameter int DSZ = 32,
  parameter int SSZ = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] din,
  input  logic [SSZ+1:0] pick,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] s0,
  output logic [DSZ-1:0] pk,
  output logic [SSZ+1:0] sp,
  output logic           ovf,
  output logic           udf
);

  localparam int SPW = SSZ + 2;
  localparam logic [SPW-1:0] CAP = SPW'((2 ** SSZ) + 2);

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_ALU  = 2'd3;

  logic           rst_meta_q, rst_sync_q;
  logic [DSZ-1:0] tos_q, tos_d;
  logic [DSZ-1:0] s0_q, s0_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;

  logic [DSZ-1:0] ram [2**SSZ];
  logic           ram_we;
  logic [SSZ-1:0] wr_addr;
  logic [SSZ-1:0] rf_addr;
  logic [SSZ-1:0] pk_addr;
  logic [DSZ-1:0] refill;

  // Reset release synchroniser; ops are ignored until it has settled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Spill slot is rp = sp-2; refill slot is rp-1, only meaningful when sp>=3.
  always_comb begin
    wr_addr = SSZ'(sp_q - SPW'(2));
    rf_addr = SSZ'(sp_q - SPW'(3));
    refill  = (sp_q >= SPW'(3)) ? ram[rf_addr] : '0;
  end

  // Next-state decode; clr wins over any op, illegal ops only raise a flag.
  always_comb begin
    tos_d  = tos_q;
    s0_d   = s0_q;
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    ram_we = 1'b0;
    if (clr) begin
      tos_d = '0;
      s0_d  = '0;
      sp_d  = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (en && rst_sync_q) begin
      case (op)
        OP_LOAD: begin
          tos_d = din;
          if (sp_q == '0) sp_d = SPW'(1);
        end
        OP_PUSH: begin
          if (sp_q == CAP) begin
            ovf_d = 1'b1;
          end else begin
            tos_d  = din;
            s0_d   = tos_q;
            ram_we = (sp_q >= SPW'(2));
            sp_d   = sp_q + SPW'(1);
          end
        end
        OP_POP: begin
          if (sp_q == '0) begin
            udf_d = 1'b1;
          end else begin
            tos_d = s0_q;
            s0_d  = refill;
            sp_d  = sp_q - SPW'(1);
          end
        end
        OP_ALU: begin
          if (sp_q < SPW'(2)) begin
            udf_d = 1'b1;
          end else begin
            tos_d = din;
            s0_d  = refill;
            sp_d  = sp_q - SPW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stack registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_q <= '0;
      s0_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      s0_q  <= s0_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Spill RAM: synchronous write, not reset (contents above sp are dead).
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_addr] <= s0_q;
  end

  // PICK port: item k>=2 sits at ram[sp-1-k]; anything at or past depth reads 0.
  always_comb begin
    pk_addr = SSZ'(sp_q - SPW'(1) - pick);
    pk      = '0;
    if (pick < sp_q) begin
      if (pick == '0)            pk = tos_q;
      else if (pick == SPW'(1))  pk = s0_q;
      else                       pk = ram[pk_addr];
    end
  end

  assign tos = tos_q;
  assign s0  = s0_q;
  assign sp  = sp_q;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule

// File: tb/tb_eforth_dstack.sv
// Bench for eforth_dstack with SSZ=3 (CAP=10): vector table plus hand sequences.
module tb_eforth_dstack;

  localparam int DSZ = 32;
  localparam int SSZ = 3;
  localparam int SPW = SSZ + 2;

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] PUSH = 2'd1;
  localparam logic [1:0] POP  = 2'd2;
  localparam logic [1:0] ALU  = 2'd3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clr = 1'b0;
  logic           en  = 1'b0;
  logic [1:0]     op  = 2'd0;
  logic [DSZ-1:0] din = '0;
  logic [SPW-1:0] pick = '0;
  logic [DSZ-1:0] tos, s0, pk;
  logic [SPW-1:0] sp;
  logic           ovf, udf;

  eforth_dstack #(.DSZ(DSZ), .SSZ(SSZ)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .op(op), .din(din), .pick(pick),
    .tos(tos), .s0(s0), .pk(pk), .sp(sp), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           c_clr;
    logic           c_en;
    logic [1:0]     c_op;
    logic [DSZ-1:0] c_din;
    logic [SPW-1:0] c_pick;
    logic [DSZ-1:0] e_tos;
    logic [DSZ-1:0] e_s0;
    logic [DSZ-1:0] e_pk;
    logic [SPW-1:0] e_sp;
    logic           e_ovf;
    logic           e_udf;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[15];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic c, input logic e, input logic [1:0] o,
                              input int d, input int p, input int t, input int s,
                              input int k, input int depth, input logic ov, input logic ud);
    vec_t v;
    v.c_clr = c;  v.c_en = e;  v.c_op = o;
    v.c_din = DSZ'(d);  v.c_pick = SPW'(p);
    v.e_tos = DSZ'(t);  v.e_s0 = DSZ'(s);  v.e_pk = DSZ'(k);
    v.e_sp = SPW'(depth);  v.e_ovf = ov;  v.e_udf = ud;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DSZ-1:0] act, input logic [DSZ-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, " tos"}, tos, e.e_tos);
    chk({tag, " s0"},  s0,  e.e_s0);
    chk({tag, " pk"},  pk,  e.e_pk);
    chk({tag, " sp"},  DSZ'(sp), DSZ'(e.e_sp));
    chk({tag, " ovf"}, DSZ'(ovf), DSZ'(e.e_ovf));
    chk({tag, " udf"}, DSZ'(udf), DSZ'(e.e_udf));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    clr = v.c_clr; en = v.c_en; op = v.c_op; din = v.c_din; pick = v.c_pick;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk_all(tag, e);
    end
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      clr = 1'b0; en = 1'b0; pick = '0;
      #1;
      chk_all(tag, mk(0, 0, LOAD, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            clr en op    din   pk  tos   s0    pk    sp ovf udf
    tbl[0]  = mk(0, 1, PUSH, 3,    0,  3,    0,    3,    1, 0, 0);
    tbl[1]  = mk(0, 1, PUSH, 4,    1,  4,    3,    3,    2, 0, 0);
    tbl[2]  = mk(0, 1, ALU,  7,    0,  7,    0,    7,    1, 0, 0);
    tbl[3]  = mk(0, 1, LOAD, 5,    1,  5,    0,    0,    1, 0, 0);
    tbl[4]  = mk(0, 1, ALU,  9,    0,  5,    0,    5,    1, 0, 1);
    tbl[5]  = mk(0, 1, POP,  0,    0,  0,    0,    0,    0, 0, 1);
    tbl[6]  = mk(0, 1, POP,  0,    0,  0,    0,    0,    0, 0, 1);
    tbl[7]  = mk(0, 0, PUSH, 'hAA, 0,  0,    0,    0,    0, 0, 1);
    tbl[8]  = mk(0, 1, LOAD, 'h11, 0,  'h11, 0,    'h11, 1, 0, 1);
    tbl[9]  = mk(0, 1, PUSH, 'h22, 1,  'h22, 'h11, 'h11, 2, 0, 1);
    tbl[10] = mk(0, 1, PUSH, 'h33, 2,  'h33, 'h22, 'h11, 3, 0, 1);
    tbl[11] = mk(0, 1, PUSH, 'h44, 3,  'h44, 'h33, 'h11, 4, 0, 1);
    tbl[12] = mk(1, 1, PUSH, 9,    0,  0,    0,    0,    0, 0, 0);
    tbl[13] = mk(0, 1, POP,  0,    0,  0,    0,    0,    0, 0, 1);
    tbl[14] = mk(1, 0, LOAD, 0,    0,  0,    0,    0,    0, 0, 0);

    // Reset asserted: outputs zero before any clock edge.
    #2;
    chk_all("reset", mk(0, 0, LOAD, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    idle_check("idle", 5);

    for (int i = 0; i < 15; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Fill to capacity in order.
    for (int i = 1; i <= 10; i++)
      step($sformatf("push%0d", i), mk(0, 1, PUSH, i, 0, i, i - 1, i, i, 0, 0));

    // PICK sweep at full depth: item k down holds 10-k; k=10 is past depth.
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      en = 1'b0; pick = SPW'(k);
      #1;
      chk($sformatf("pick%0d", k), pk, (k < 10) ? DSZ'(10 - k) : '0);
    end

    // Overflow: ignored push, flag sticks through the pops.
    step("ovf push", mk(0, 1, PUSH, 99, 0, 10, 9, 10, 10, 1, 0));
    for (int i = 9; i >= 0; i--)
      step($sformatf("pop_to%0d", i), mk(0, 1, POP, 0, 0, i, (i > 0) ? i - 1 : 0, i, i, 1, 0));
    step("clr", mk(1, 0, LOAD, 0, 0, 0, 0, 0, 0, 0, 0));

    // Spill then immediate refill of the same RAM slot.
    step("rw push a", mk(0, 1, PUSH, 'hA, 0, 'hA, 0,   'hA, 1, 0, 0));
    step("rw push b", mk(0, 1, PUSH, 'hB, 0, 'hB, 'hA, 'hB, 2, 0, 0));
    step("rw push c", mk(0, 1, PUSH, 'hC, 2, 'hC, 'hB, 'hA, 3, 0, 0));
    step("rw pop c",  mk(0, 1, POP,  0,   0, 'hB, 'hA, 'hB, 2, 0, 0));
    step("rw push d", mk(0, 1, PUSH, 'hD, 2, 'hD, 'hB, 'hA, 3, 0, 0));
    step("rw alu",    mk(0, 1, ALU,  'hE, 1, 'hE, 'hA, 'hA, 2, 0, 0));

    // Asynchronous reset mid-sequence, then recovery.
    @(negedge clk);
    en = 1'b0; pick = '0;
    #2;
    rst = 1'b0;
    #1;
    chk_all("async rst", mk(0, 0, LOAD, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    idle_check("post rst", 3);
    step("post rst push", mk(0, 1, PUSH, 7, 0, 7, 0, 7, 1, 0, 0));

    @(negedge clk);
    en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
